// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths and FSM states for the line memory responder
package dmem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port line store with registered, write-first read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register only moves on an access, so it holds the last line between acks.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency 256-bit line responder for the data cache memory port
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam bit DIRECT = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic [IDX_W-1:0]  line_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ack_q;
    logic              busy_q;

    logic              complete_d;
    logic              arr_we_d;
    logic [IDX_W-1:0]  arr_idx_d;
    logic [LINE_W-1:0] arr_wdata_d;
    logic              unused_addr;

    assign unused_addr = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

    // With LATENCY=1 the access happens on the accepting edge, so it uses live inputs.
    always_comb begin
        complete_d  = 1'b0;
        arr_we_d    = write_q;
        arr_idx_d   = line_q;
        arr_wdata_d = wdata_q;
        if (state_q == IDLE) begin
            complete_d  = DIRECT && enable_i;
            arr_we_d    = write_i;
            arr_idx_d   = addr_i[OFFSET_W +: IDX_W];
            arr_wdata_d = data_i;
        end else if (state_q == WAIT) begin
            complete_d = (cnt_q == CNT_ONE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            line_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        write_q <= write_i;
                        line_q  <= addr_i[OFFSET_W +: IDX_W];
                        wdata_q <= data_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= DIRECT ? ACK : WAIT;
                        ack_q   <= DIRECT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (complete_d),
        .we_i    (arr_we_d),
        .addr_i  (arr_idx_d),
        .wdata_i (arr_wdata_d),
        .rdata_o (data_o)
    );

    assign ack_o  = ack_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en0, en1, wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack0, ack1, busy0, busy1;
    logic [255:0] rdata0, rdata1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit sel = 1'b0;
    logic [255:0] model [2][512];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH(512), .LATENCY(10)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en0), .write_i(wr), .addr_i(addr),
        .data_i(wdata), .ack_o(ack0), .data_o(rdata0), .busy_o(busy0)
    );

    dmem_responder #(.DEPTH(512), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr), .addr_i(addr),
        .data_i(wdata), .ack_o(ack1), .data_o(rdata1), .busy_o(busy1)
    );

    wire         ack_s  = sel ? ack1 : ack0;
    wire         busy_s = sel ? busy1 : busy0;
    wire [255:0] data_s = sel ? rdata1 : rdata0;

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] rand_addr(input int idx);
        logic [31:0] a;
        a = $urandom();
        a[13:5] = idx[8:0];
        return a;
    endfunction

    // Starts at a falling edge with the responder idle; ends at the falling edge after return to IDLE.
    task automatic do_txn(input bit w, input logic [31:0] a, input logic [255:0] d,
                          input bit drop, input string tag);
        int lat;
        int n;
        int bad;
        bit seen;
        int idx;
        logic [255:0] expv;
        lat  = sel ? 1 : 10;
        idx  = int'(a[13:5]);
        expv = w ? d : model[sel][idx];
        if (w) model[sel][idx] = d;
        if (sel) en1 = 1'b1; else en0 = 1'b1;
        wr = w; addr = a; wdata = d;
        @(posedge clk);
        n = 0; bad = 0; seen = 1'b0;
        while (!seen && n < lat + 5) begin
            @(negedge clk);
            n++;
            if (ack_s) seen = 1'b1;
            else begin
                if (busy_s !== 1'b1) bad++;
                if (drop && n == 1) begin
                    en0 = 1'b0; en1 = 1'b0;
                    wr = ~w; addr = rand_addr($urandom_range(15)); wdata = rand_line();
                end
            end
        end
        checks++;
        if (!seen || n != lat) begin
            failures++;
            $display("FAIL %s latency: ack at %0d (seen=%0d) expected %0d", tag, n, seen, lat);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s wait_busy: %0d cycles with busy low, expected 0", tag, bad);
        end
        checks++;
        if (data_s !== expv) begin
            failures++;
            $display("FAIL %s data: got %h expected %h", tag, data_s, expv);
        end
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0 || ack_s !== 1'b0) begin
            failures++;
            $display("FAIL %s back_to_idle: busy=%b ack=%b expected 0 0", tag, busy_s, ack_s);
        end
        en0 = 1'b0; en1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en0 = 1'b1; en1 = 1'b0; wr = 1'b1;
        addr = 32'h80; wdata = {32{8'hA5}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== '0) begin
                failures++;
                $display("FAIL reset_state: ack=%b busy=%b data=%h expected 0", ack0, busy0, rdata0);
            end
        end
        rst_n = 1'b1;
        do_txn(1'b1, 32'h80, {32{8'hA5}}, 1'b0, "reset_first_write");
    endtask

    task automatic test_read_latency();
        do_txn(1'b0, 32'h0000_0080, '0, 1'b0, "read_latency");
    endtask

    task automatic test_preload();
        for (int i = 0; i < 16; i++) do_txn(1'b1, rand_addr(i), rand_line(), 1'b0, "preload");
    endtask

    task automatic test_write_read();
        int c0;
        c0 = cyc;
        do_txn(1'b1, 32'h0000_0020, {16{16'h1234}}, 1'b0, "wr_pair_write");
        do_txn(1'b0, 32'h0000_0020, '0, 1'b0, "wr_pair_read");
        checks++;
        if (cyc - c0 != 22) begin
            failures++;
            $display("FAIL pair_cycles: got %0d expected 22", cyc - c0);
        end
    endtask

    task automatic test_offset_wrap();
        do_txn(1'b1, 32'h0000_003F, rand_line(), 1'b0, "offset_write");
        do_txn(1'b0, 32'h0000_4020, '0, 1'b0, "wrap_read");
    endtask

    task automatic test_drop();
        do_txn(1'b1, rand_addr(9), rand_line(), 1'b1, "drop_write");
        do_txn(1'b0, rand_addr(9), '0, 1'b0, "drop_readback");
        do_txn(1'b0, rand_addr(4), '0, 1'b1, "drop_read");
    endtask

    task automatic test_reset_mid_wait();
        int acks;
        do_txn(1'b1, 32'h0000_00E0, rand_line(), 1'b0, "pre_line7");
        en0 = 1'b1; wr = 1'b1; addr = 32'h0000_00E0; wdata = rand_line();
        @(posedge clk);
        for (int i = 0; i < 4; i++) @(negedge clk);
        en0 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== '0) begin
            failures++;
            $display("FAIL mid_wait_reset: ack=%b busy=%b data=%h expected 0", ack0, busy0, rdata0);
        end
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL aborted_ack: got %0d acks expected 0", acks);
        end
        do_txn(1'b0, 32'h0000_00E0, '0, 1'b0, "line7_unchanged");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit w;
            w = 1'($urandom_range(1));
            do_txn(w, rand_addr($urandom_range(15)), rand_line(), 1'b0, "random");
        end
    endtask

    task automatic test_latency1();
        int c0;
        sel = 1'b1;
        c0 = cyc;
        do_txn(1'b1, rand_addr(3), rand_line(), 1'b0, "lat1_write");
        do_txn(1'b0, rand_addr(3), '0, 1'b0, "lat1_read");
        checks++;
        if (cyc - c0 != 4) begin
            failures++;
            $display("FAIL lat1_pair_cycles: got %0d expected 4", cyc - c0);
        end
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = (i < 4) ? 20 + i : 20 + (i - 4);
            do_txn(i < 4, rand_addr(idx), rand_line(), 1'b0, "lat1_seq");
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_preload();
        test_write_read();
        test_offset_wrap();
        test_drop();
        test_reset_mid_wait();
        test_random();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
